morra_match_ctrl: RTL



---
 rtl/morra_match_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/morra_match_ctrl.sv
// Match sequencer for the morra engine: buffers one move per player, issues each move pair and tracks the match result.
// Optional MATCH_STATS_EN adds saturating invalid-manche and draw counters (inv_cnt, draw_cnt).
module morra_match_ctrl #(
  parameter int ENG_LAT = 1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfg_p,
  input  logic [1:0]       cfg_s,
  input  logic             p_valid,
  input  logic [1:0]       p_move,
  output logic             p_ready,
  input  logic             s_valid,
  input  logic [1:0]       s_move,
  output logic             s_ready,
  output logic             eng_i,
  output logic [1:0]       eng_p,
  output logic [1:0]       eng_s,
  input  logic [1:0]       eng_m,
  input  logic [1:0]       eng_pa,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic             forfeit,
`ifdef MATCH_STATS_EN
  output logic [3:0]       inv_cnt,
  output logic [3:0]       draw_cnt,
`endif
  output logic [CNT_W-1:0] manche_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_COLLECT, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  localparam int             TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [2:0]     LAT_LAST = 3'(ENG_LAT);

  state_t           state_q, state_d;
  logic [1:0]       cfg_p_q, cfg_p_d, cfg_s_q, cfg_s_d;
  logic [1:0]       p_buf_q, p_buf_d, s_buf_q, s_buf_d;
  logic             p_full_q, p_full_d, s_full_q, s_full_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [1:0]       winner_q, winner_d;
  logic             forfeit_q, forfeit_d;
  logic [CNT_W-1:0] mc_q, mc_d;
  logic             done_q, done_d;
`ifdef MATCH_STATS_EN
  logic [3:0]       inv_q, inv_d, draw_q, draw_d;
`endif

  logic p_take, s_take;

  // Illegal move 00 completes the handshake but never fills the buffer.
  assign p_take = p_ready && p_valid && (p_move != 2'b00);
  assign s_take = s_ready && s_valid && (s_move != 2'b00);

  always_comb begin
    state_d   = state_q;
    cfg_p_d   = cfg_p_q;
    cfg_s_d   = cfg_s_q;
    p_buf_d   = p_buf_q;
    s_buf_d   = s_buf_q;
    p_full_d  = p_full_q;
    s_full_d  = s_full_q;
    to_cnt_d  = to_cnt_q;
    lat_cnt_d = lat_cnt_q;
    winner_d  = winner_q;
    forfeit_d = forfeit_q;
    mc_d      = mc_q;
`ifdef MATCH_STATS_EN
    inv_d     = inv_q;
    draw_d    = draw_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_INIT;
          cfg_p_d   = cfg_p;
          cfg_s_d   = cfg_s;
          p_full_d  = 1'b0;
          s_full_d  = 1'b0;
          to_cnt_d  = '0;
          winner_d  = 2'b00;
          forfeit_d = 1'b0;
          mc_d      = '0;
`ifdef MATCH_STATS_EN
          inv_d     = '0;
          draw_d    = '0;
`endif
        end
      end
      S_INIT: state_d = S_COLLECT;
      S_COLLECT: begin
        if (p_take) begin
          p_full_d = 1'b1;
          p_buf_d  = p_move;
        end
        if (s_take) begin
          s_full_d = 1'b1;
          s_buf_d  = s_move;
        end
        // A pair completing this cycle wins over an expiring timeout.
        if (p_full_d && s_full_d) begin
          state_d  = S_ISSUE;
          to_cnt_d = '0;
        end else if ((TIMEOUT != 0) && (p_full_q ^ s_full_q)) begin
          if (to_cnt_q == TO_LAST) begin
            state_d   = S_DONE;
            forfeit_d = 1'b1;
            winner_d  = p_full_q ? 2'b01 : 2'b10;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        p_full_d  = 1'b0;
        s_full_d  = 1'b0;
        lat_cnt_d = 3'd1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          if ((eng_m != 2'b00) && (mc_q != {CNT_W{1'b1}})) mc_d = mc_q + 1'b1;
`ifdef MATCH_STATS_EN
          if ((eng_m == 2'b00) && (inv_q != 4'hF))  inv_d  = inv_q + 4'd1;
          if ((eng_m == 2'b11) && (draw_q != 4'hF)) draw_d = draw_q + 4'd1;
`endif
          if (eng_pa != 2'b00) begin
            winner_d = eng_pa;
            state_d  = S_DONE;
          end else begin
            state_d  = S_COLLECT;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cfg_p_q   <= 2'b00;
      cfg_s_q   <= 2'b00;
      p_buf_q   <= 2'b00;
      s_buf_q   <= 2'b00;
      p_full_q  <= 1'b0;
      s_full_q  <= 1'b0;
      to_cnt_q  <= '0;
      lat_cnt_q <= 3'd0;
      winner_q  <= 2'b00;
      forfeit_q <= 1'b0;
      mc_q      <= '0;
      done_q    <= 1'b0;
`ifdef MATCH_STATS_EN
      inv_q     <= 4'd0;
      draw_q    <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      cfg_p_q   <= cfg_p_d;
      cfg_s_q   <= cfg_s_d;
      p_buf_q   <= p_buf_d;
      s_buf_q   <= s_buf_d;
      p_full_q  <= p_full_d;
      s_full_q  <= s_full_d;
      to_cnt_q  <= to_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      winner_q  <= winner_d;
      forfeit_q <= forfeit_d;
      mc_q      <= mc_d;
      done_q    <= done_d;
`ifdef MATCH_STATS_EN
      inv_q     <= inv_d;
      draw_q    <= draw_d;
`endif
    end
  end

  assign p_ready    = (state_q == S_COLLECT) && !p_full_q;
  assign s_ready    = (state_q == S_COLLECT) && !s_full_q;
  assign eng_i      = (state_q == S_INIT);
  assign eng_p      = (state_q == S_INIT)  ? cfg_p_q :
                      (state_q == S_ISSUE) ? p_buf_q : 2'b00;
  assign eng_s      = (state_q == S_INIT)  ? cfg_s_q :
                      (state_q == S_ISSUE) ? s_buf_q : 2'b00;
  assign busy       = (state_q == S_INIT) || (state_q == S_COLLECT) ||
                      (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done       = done_q;
  assign winner     = winner_q;
  assign forfeit    = forfeit_q;
  assign manche_cnt = mc_q;
`ifdef MATCH_STATS_EN
  assign inv_cnt    = inv_q;
  assign draw_cnt   = draw_q;
`endif

endmodule
